// File: rtl/adder_arbiter.sv
// Round-robin scheduler that time-shares one external combinational adder among NREQ
// requesters; one operand pair per transaction, sum returned with the requester ID.
module adder_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_y,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_data,
  input  logic                  res_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [NREQ-1:0]  r_gnt;
  logic             r_res_valid;
  logic [IDW-1:0]   r_res_id;
  logic [WIDTH-1:0] r_res_data;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_ptr_nxt;

  // Scan downward so the lowest offset from r_ptr is the last, and winning, assignment.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin : win_select
    int j;
    w_found = 1'b0;
    w_win   = '0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        w_found = 1'b1;
        w_win   = IDW'(j);
      end
    end
  end

  assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: operand and result registers are reset too, because add_a/add_b/res_data must read 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_gnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
    end else begin
      r_gnt <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_opa    <= a_in[int'(w_win)*WIDTH +: WIDTH];
            r_opb    <= b_in[int'(w_win)*WIDTH +: WIDTH];
            r_res_id <= w_win;
            r_gnt    <= NREQ'(1) << w_win;
            r_ptr    <= w_ptr_nxt;
            r_state  <= S_ADD;
          end
        end
        S_ADD: begin
          r_res_data  <= add_y;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign add_a     = r_opa;
  assign add_b     = r_opb;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_data  = r_res_data;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: transaction-level reference model compared every
// cycle under random traffic, plus directed scenarios with hand-computed expectations.
module tb_adder_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in, b_in;
  logic [N-1:0]   gnt;
  logic [W-1:0]   add_a, add_b, add_y;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [W-1:0]   res_data;
  logic           res_ready;
  logic           busy;

  logic [N3-1:0]   req3;
  logic [N3*W-1:0] a3, b3;
  logic [N3-1:0]   gnt3;
  logic [W-1:0]    add_a3, add_b3, add_y3;
  logic            res_valid3;
  logic [1:0]      res_id3;
  logic [W-1:0]    res_data3;
  logic            ready3;
  logic            busy3;

  adder_arbiter #(.WIDTH(W), .NREQ(N)) u_dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .add_a(add_a), .add_b(add_b), .add_y(add_y), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data), .res_ready(res_ready), .busy(busy)
  );

  adder_arbiter #(.WIDTH(W), .NREQ(N3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .a_in(a3), .b_in(b3), .gnt(gnt3),
    .add_a(add_a3), .add_b(add_b3), .add_y(add_y3), .res_valid(res_valid3), .res_id(res_id3),
    .res_data(res_data3), .res_ready(ready3), .busy(busy3)
  );

  // The shared combinational adder lives outside the arbiter.
  assign add_y  = add_a + add_b;
  assign add_y3 = add_a3 + add_b3;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction in flight at most; age 0 = grant cycle, age 1 = result offered.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  bit           m_act;
  int           m_age;
  int           m_id;
  int           m_ptr;
  logic [W-1:0] m_opa, m_opb, m_data;

  always @(posedge clk or posedge reset) begin
    int w;
    if (reset) begin
      m_act <= 1'b0; m_age <= 0; m_id <= 0; m_ptr <= 0;
      m_opa <= '0;  m_opb <= '0; m_data <= '0;
    end else if (!m_act) begin
      if (req != '0) begin
        w = rr_pick(req, m_ptr);
        m_id  <= w;
        m_opa <= a_in[w*W +: W];
        m_opb <= b_in[w*W +: W];
        m_ptr <= (w + 1) % N;
        m_act <= 1'b1;
        m_age <= 0;
      end
    end else if (m_age == 0) begin
      m_age  <= 1;
      m_data <= m_opa + m_opb;
    end else if (res_ready) begin
      m_act <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("gnt",       64'(gnt),       (m_act && m_age == 0) ? (64'(1) << m_id) : 64'(0));
      check("res_valid", 64'(res_valid), 64'(m_act && m_age == 1));
      check("res_id",    64'(res_id),    64'(m_id));
      check("res_data",  64'(res_data),  64'(m_data));
      check("add_a",     64'(add_a),     64'(m_opa));
      check("add_b",     64'(add_b),     64'(m_opb));
      check("busy",      64'(busy),      64'(m_act));
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  // Bounded wait on a DUT event; an expired budget is recorded as a failed comparison.
  task automatic wait_for(input int sel, input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      case (sel)
        0:       ok = (gnt != '0);
        1:       ok = res_valid;
        2:       ok = (gnt3 != '0);
        default: ok = res_valid3;
      endcase
    end
    if (!ok) check({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic run_random(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else set_op(i, $urandom, $urandom);
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          req[i] = 1'b1;
          set_op(i, $urandom, $urandom);
        end
      end
      res_ready = ($urandom_range(9, 0) < 6);
    end
  endtask

  initial begin
    bit ok;
    int g_cyc[5];
    int r_id[5];
    int r_dat[5];
    int ng, nr;
    int exp_ids[5];
    exp_ids = '{0, 1, 2, 3, 0};

    reset = 1'b1; req = '0; a_in = '0; b_in = '0; res_ready = 1'b0;
    req3 = '0; a3 = '0; b3 = '0; ready3 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt",   64'(gnt),       64'(0));
    check("rst_valid", 64'(res_valid), 64'(0));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_data",  64'(res_data),  64'(0));
    check("rst_add_a", 64'(add_a),     64'(0));
    #2 reset = 1'b0;

    // Single add from requester 1.
    set_op(1, 32'h10, 32'h20); req = 4'b0010; res_ready = 1'b1;
    wait_for(0, "single_gnt", ok);
    check("single_gnt", 64'(gnt), 64'h2);
    req = '0;
    @(negedge clk);
    check("single_gnt_pulse", 64'(gnt),       64'(0));
    check("single_valid",     64'(res_valid), 64'(1));
    check("single_id",        64'(res_id),    64'(1));
    check("single_data",      64'(res_data),  64'h30);
    check("single_busy",      64'(busy),      64'(1));
    @(negedge clk);
    check("single_valid_fall", 64'(res_valid), 64'(0));
    check("single_busy_fall",  64'(busy),      64'(0));

    // Modulo-2^W wrap of the sum.
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0002); req = 4'b0001;
    wait_for(0, "wrap_gnt", ok);
    req = '0;
    @(negedge clk);
    check("wrap_data", 64'(res_data), 64'h1);
    @(negedge clk);

    // Round-robin with all requesters held high from ptr = 0.
    pulse_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i), W'(100));
    req = 4'b1111; res_ready = 1'b1;
    ng = 0; nr = 0;
    for (int c = 0; c < 30 && nr < 5; c++) begin
      @(negedge clk);
      if (gnt != '0 && ng < 5) begin
        check("rr_onehot", 64'($onehot(gnt)), 64'(1));
        g_cyc[ng] = cyc;
        ng++;
      end
      if (res_valid) begin
        r_id[nr]  = int'(res_id);
        r_dat[nr] = int'(res_data);
        nr++;
      end
    end
    req = '0;
    check("rr_count", 64'(nr), 64'(5));
    for (int k = 0; k < nr; k++) begin
      check("rr_id",   64'(r_id[k]),  64'(exp_ids[k]));
      check("rr_data", 64'(r_dat[k]), 64'(100 + exp_ids[k]));
    end
    for (int k = 0; k + 1 < ng; k++) check("rr_spacing", 64'(g_cyc[k+1] - g_cyc[k]), 64'(3));
    repeat (3) @(negedge clk);

    // Backpressure: result held, req ignored while res_ready is low.
    set_op(2, 32'd3, 32'd4); req = 4'b0100; res_ready = 1'b0;
    wait_for(0, "bp_gnt", ok);
    req = '0;
    wait_for(1, "bp_valid", ok);
    for (int c = 0; c < 5; c++) begin
      req = 4'($urandom);
      @(negedge clk);
      check("bp_valid", 64'(res_valid), 64'(1));
      check("bp_id",    64'(res_id),    64'(2));
      check("bp_data",  64'(res_data),  64'(7));
      check("bp_no_gnt", 64'(gnt),      64'(0));
    end
    req = 4'b0001; set_op(0, 32'd1, 32'd1); res_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_fall", 64'(res_valid), 64'(0));
    check("bp_gnt_wait",   64'(gnt),       64'(0));
    @(negedge clk);
    check("bp_next_gnt",   64'(gnt),       64'h1);
    req = '0;
    repeat (2) @(negedge clk);

    // Reset while a result is pending in DONE.
    set_op(0, 32'd9, 32'd9); req = 4'b0001; res_ready = 1'b0;
    wait_for(0, "rst_mid_gnt", ok);
    req = '0;
    wait_for(1, "rst_mid_valid", ok);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valid", 64'(res_valid), 64'(0));
    check("rst_mid_gnt",   64'(gnt),       64'(0));
    check("rst_mid_busy",  64'(busy),      64'(0));
    check("rst_mid_data",  64'(res_data),  64'(0));
    @(negedge clk);
    #2 reset = 1'b0;
    set_op(0, 32'd5, 32'd7); req = 4'b0001; res_ready = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", 64'(gnt), 64'h1);
    req = '0;
    @(negedge clk);
    check("post_rst_valid", 64'(res_valid), 64'(1));
    check("post_rst_id",    64'(res_id),    64'(0));
    check("post_rst_data",  64'(res_data),  64'd12);
    @(negedge clk);

    // Random traffic against the model.
    run_random(600);
    req = '0; res_ready = 1'b1;
    repeat (5) @(negedge clk);

    // Pointer wrap on a 3-requester instance.
    a3[2*W +: W] = 32'd10; b3[2*W +: W] = 32'd20;
    a3[0*W +: W] = 32'd1;  b3[0*W +: W] = 32'd2;
    req3 = 3'b100; ready3 = 1'b1;
    wait_for(2, "p3_gnt_a", ok);
    check("p3_gnt_a", 64'(gnt3), 64'h4);
    req3 = '0;
    @(negedge clk);
    check("p3_id_a",   64'(res_id3),   64'(2));
    check("p3_data_a", 64'(res_data3), 64'd30);
    @(negedge clk);
    req3 = 3'b101;
    wait_for(2, "p3_gnt_b", ok);
    check("p3_gnt_b", 64'(gnt3), 64'h1);
    req3 = '0;
    @(negedge clk);
    check("p3_valid_b", 64'(res_valid3), 64'(1));
    check("p3_id_b",    64'(res_id3),    64'(0));
    check("p3_data_b",  64'(res_data3),  64'd3);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin scheduler that shares one combinational `adder` instance among `NREQ` requesters (ball/paddle position updates, score counters). It sits between the requesters and the adder: it accepts one operand pair at a time over a req/gnt handshake, drives the shared adder, and registers the sum. It returns the sum with the requester ID over a valid/ready handshake. Sums wrap modulo 2^WIDTH, matching the adder.

## Interface
- `WIDTH`, 32, operand/result width; passed through to the shared adder.
- `NREQ`, 4, number of requesters; 2..8; need not be a power of 2.
- `IDW`, $clog2(NREQ), requester-ID width; derived, not overridden.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  NREQ  `req[i]` high: requester i has a pending operand pair.
- `a_in`  in  NREQ*WIDTH  operand A; slice i is `[i*WIDTH +: WIDTH]`.
- `b_in`  in  NREQ*WIDTH  operand B; same slicing.
- `gnt`  out  NREQ  one-hot, one-cycle pulse: the operands of requester i were captured.
- `add_a`  out  WIDTH  to shared adder input a.
- `add_b`  out  WIDTH  to shared adder input b.
- `add_y`  in  WIDTH  from shared adder output y.
- `res_valid`  out  1  result available.
- `res_id`  out  IDW  requester ID of the result.
- `res_data`  out  WIDTH  registered sum.
- `res_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, ADD, DONE. Reset state is IDLE.
- **IDLE:**
  - If `req` is all zero, stay in IDLE.
  - Otherwise pick the winner w: the first set `req` bit scanning from `ptr` upward, wrapping at NREQ-1 to 0.
  - Capture operand slices w into the `opa`/`opb` registers, set `res_id <= w`, `gnt <= onehot(w)`, `ptr <= (w+1) mod NREQ`. Go to ADD.
- **ADD:**
  - `gnt` is high this cycle only.
  - `add_a`/`add_b` drive `opa`/`opb`. They are driven directly from the registers in every state; no mux glitches depend on state.
  - On the clock edge: `res_data <= add_y`, `res_valid <= 1`. Go to DONE.
- **DONE:**
  - Hold `res_valid`, `res_id` and `res_data` stable until `res_ready` is sampled high.
  - On that edge: `res_valid <= 0`. Go to IDLE.
  - `req` is ignored in ADD and DONE.
- Requester rules:
  - Hold `req[i]` and operands stable until `gnt[i]` is seen.
  - Drop `req[i]` on the edge that samples `gnt[i]`, or hold it to queue a further operation with new operands.
  - A `req` that stays high after its grant is treated as a new request at the next IDLE.
- Arithmetic: `res_data` = (a+b) mod 2^WIDTH. Carry-out is discarded; no overflow flag.

## Timing
- Reset values: state IDLE, `gnt` 0, `res_valid` 0, `res_id` 0, `res_data` 0, `opa`/`opb` 0 (so `add_a`/`add_b` are 0), `ptr` 0, `busy` 0.
- Latency, with edge E0 as the IDLE edge that samples `req`:
  - `gnt` is high between E0 and E1.
  - `res_valid` rises after E1.
  - Earliest `res_valid` fall is after E2, with `res_ready` already high.
  - Next grant is at E3.
- Throughput: one operation per 3 cycles at best. Each extra cycle `res_ready` stays low adds one cycle.
- Fairness: a requester held high waits at most NREQ-1 other operations.
- Simultaneous requests: resolved purely by `ptr`; no fixed priority.
- `res_ready` high outside DONE has no effect.
- `reset` asserted in any state: the in-flight operation is discarded, no `gnt` or `res_valid` is emitted afterwards, and `ptr` returns to 0.
- `reset` release: the first grant may occur at the first rising edge after deassertion.

## Test plan
- **Reset values:** assert `reset` mid-operation, while in DONE with `res_valid`=1 -> `res_valid`, `gnt`, `busy` and `res_data` read 0 immediately. After release with `req`=0001 and operands 5,7, the first grant is to ID 0 and the result is 12.
- **Single add:** `req`=0010, a1=0x0000_0010, b1=0x0000_0020, `res_ready`=1 -> `gnt`=0010 for one cycle; after two edges `res_valid`=1, `res_id`=1, `res_data`=0x30; `busy` falls one cycle later.
- **Round-robin:** `req`=1111 held constantly, operand pair i = (i, 100) -> result order IDs 0,1,2,3,0 with data 100,101,102,103,100; every `gnt` is one-hot and the grants are 3 cycles apart.
- **Backpressure:** `res_ready` held low for 5 cycles in DONE -> `res_valid`, `res_id` and `res_data` stay stable, no new `gnt` is issued, and `req` changes are ignored. After `res_ready` rises, the next grant follows 1 cycle after `res_valid` falls.
- **Wrap-around:** a=0xFFFF_FFFF, b=0x0000_0002 -> `res_data`=0x0000_0001, no other flag.
- **Pointer wrap:** NREQ=3; `req`=100, then after completion `req`=101 -> grants are ID 2 then ID 0.
